ms_arbiter: RTL and testbench
=============================

MS_ARBITER -- requirements
Module: ms_arbiter

Interface
REQ-001 The module SHALL expose parameter DEPTH_TAG, default 4, meaning the maximum number of operations in flight in MultShift (power of two, 2..8).
REQ-002 The module SHALL expose the following ports, one per line:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Active  in  1  enables new grants.
- I_Opcode0 / I_Opcode1  in  opcode_ms_t  opcode of requester 0 / 1.
- I_FTkA0, I_FTkB0 / I_FTkA1, I_FTkB1  in  FTk_t  operand pairs of requester 0 / 1.
- O_BTk0 / O_BTk1  out  BTk_t  backward token to requester 0 / 1.
- O_Result0 / O_Result1  out  FTk_t  routed result to requester 0 / 1.
- I_BTk0 / I_BTk1  in  BTk_t  backward token from the result consumer of requester 0 / 1.
- O_MS_Opcode  out  opcode_ms_t  opcode to MultShift.
- O_MS_OperandA, O_MS_OperandB  out  FTk_t  operands to MultShift.
- O_MS_EnSrc  out  1  drives both MultShift source enables.
- I_MS_BTk  in  BTk_t  MultShift operand backward token (uses O_BTkA).
- I_MS_Result  in  FTk_t  MultShift result.
- O_MS_BTk  out  BTk_t  backward token into MultShift.
- O_State  out  2  FSM state.
- O_Err  out  1  sticky orphan-result error.

Function
REQ-003 Requester k SHALL be pending when I_FTkAk.v and I_FTkBk.v are both 1.
REQ-004 A grant SHALL occur when the FSM is in RUN, at least one requester is pending, I_MS_BTk.n=0, and the tag FIFO is not full, or it is full and pops in the same cycle.
REQ-005 With both requesters pending, the grant SHALL alternate round-robin, with requester 0 first after reset; the last-granted pointer SHALL update only on a grant.
REQ-006 The granted operands and opcode SHALL be registered and presented on O_MS_* exactly 1 cycle after the grant, with O_MS_EnSrc=1 for that single cycle; otherwise O_MS_OperandA/B SHALL be '0 and O_MS_EnSrc=0.
REQ-007 O_BTkk.n SHALL be 1 whenever requester k is pending and not granted that cycle; O_BTkk.n SHALL be 0 in the grant cycle; O_BTkk.t, .v and .c SHALL be 0.
REQ-008 Each grant SHALL push the requester ID (1 bit) into an in-order tag FIFO of depth DEPTH_TAG.
REQ-009 When I_MS_Result.v=1, the head tag k SHALL be popped and I_MS_Result registered onto O_Resultk (latency 1 cycle); the other O_Result SHALL hold .v=0.
REQ-010 If I_BTkk.n=1 while the head tag is k, O_MS_BTk.n SHALL be 1, the pop and the O_Resultk update SHALL be suppressed, and the registered result SHALL be held.
REQ-011 An I_MS_Result.r release token SHALL be forwarded to the O_Result of the head tag without popping.
REQ-012 If I_MS_Result.v=1 with the FIFO empty, O_Err SHALL set and stay 1 until reset, and the result SHALL be dropped.
REQ-013 The FSM states SHALL be IDLE=0, RUN=1, DRAIN=2.
- IDLE->RUN when I_Active=1.
- RUN->DRAIN when I_Active=0 and the FIFO is non-empty.
- RUN->IDLE when I_Active=0 and the FIFO is empty.
- DRAIN->IDLE when the FIFO becomes empty.
- DRAIN->RUN when I_Active=1.
REQ-014 No grant SHALL occur in IDLE or DRAIN; results SHALL still be routed in DRAIN.
REQ-015 A push and a pop in the same cycle SHALL leave the occupancy unchanged; the pointers SHALL wrap modulo DEPTH_TAG.

Reset
REQ-016 On reset assertion, without waiting for a clock edge:
- the FSM SHALL go to IDLE;
- the FIFO SHALL empty;
- the RR pointer SHALL select requester 0;
- O_Err, all O_Result*, O_MS_* and O_BTk* SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard in-flight tags; results arriving after release with the FIFO empty SHALL set O_Err.

Configuration
REQ-018 With ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when both are pending and the RR pointer SHALL be removed; without the macro, REQ-005 applies.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Both pending continuously for 4 cycles in RUN -> grants 0,1,0,1; operands on O_MS 1 cycle later; non-granted O_BTk.n=1.
- DEPTH_TAG=4, 4 grants with no results -> 5th request nacked; result plus new request in the same cycle -> grant accepted, occupancy stays 4.
- Tags 0,1 queued, I_BTk0.n=1 for 3 cycles on the result -> O_MS_BTk.n=1 for 3 cycles, then O_Result0 carries the data, then O_Result1 on the next result.
- I_Active drops with 2 outstanding -> O_State=2, no grants, IDLE after 2 results routed.
- Result with the FIFO empty -> O_Err=1, persisting until reset.
- Reset asserted with 3 outstanding -> all outputs 0 immediately, O_State=0; ARB_FIXED_PRIO_EN build with both pending -> requester 0 granted every cycle.

Source files
------------

// File: rtl/ms_arbiter.sv
// ms_arbiter: two-requester arbiter in front of a shared MultShift unit, with in-order result routing via a tag FIFO.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
`default_nettype none

package ms_arbiter_pkg;
  localparam int c_DATA_W = 16;

  typedef logic [3:0] opcode_ms_t;

  typedef struct packed {
    logic                v;
    logic                r;
    logic [c_DATA_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module ms_arbiter
  import ms_arbiter_pkg::*;
#(
  parameter int DEPTH_TAG = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       I_Active,
  input  opcode_ms_t I_Opcode0,
  input  opcode_ms_t I_Opcode1,
  input  FTk_t       I_FTkA0,
  input  FTk_t       I_FTkB0,
  input  FTk_t       I_FTkA1,
  input  FTk_t       I_FTkB1,
  output BTk_t       O_BTk0,
  output BTk_t       O_BTk1,
  output FTk_t       O_Result0,
  output FTk_t       O_Result1,
  input  BTk_t       I_BTk0,
  input  BTk_t       I_BTk1,
  output opcode_ms_t O_MS_Opcode,
  output FTk_t       O_MS_OperandA,
  output FTk_t       O_MS_OperandB,
  output logic       O_MS_EnSrc,
  input  BTk_t       I_MS_BTk,
  input  FTk_t       I_MS_Result,
  output BTk_t       O_MS_BTk,
  output logic [1:0] O_State,
  output logic       O_Err
);

  localparam int           c_PW    = (DEPTH_TAG > 1) ? $clog2(DEPTH_TAG) : 1;
  localparam logic [c_PW:0] c_FULL = (c_PW+1)'(DEPTH_TAG);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_run;

  logic [DEPTH_TAG-1:0] r_tag;
  logic [c_PW-1:0]      r_wptr;
  logic [c_PW-1:0]      r_rptr;
  logic [c_PW:0]        r_count;
  logic [c_PW:0]        w_count_nxt;

  logic                 w_pend0;
  logic                 w_pend1;
  logic                 w_gnt;
  logic                 w_gnt_id;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_head;
  logic                 w_stall;
  logic                 w_pop;
  logic                 w_rel;
  logic                 w_orphan;
  logic                 w_nack0;
  logic                 w_nack1;

  opcode_ms_t           r_ms_op;
  FTk_t                 r_ms_a;
  FTk_t                 r_ms_b;
  logic                 r_ms_en;
  FTk_t                 r_res0;
  FTk_t                 r_res1;
  logic                 r_err;

  assign w_pend0 = I_FTkA0.v & I_FTkB0.v;
  assign w_pend1 = I_FTkA1.v & I_FTkB1.v;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_head  = r_tag[r_rptr];

  // A consumer that is not ready blocks the head of the in-order stream.
  assign w_stall  = ~w_empty & (w_head ? I_BTk1.n : I_BTk0.n);
  assign w_pop    = I_MS_Result.v & ~w_empty & ~w_stall;
  assign w_rel    = I_MS_Result.r & ~I_MS_Result.v & ~w_empty & ~w_stall;
  assign w_orphan = I_MS_Result.v & w_empty;

  assign w_gnt = w_run & I_Active & (w_pend0 | w_pend1) & ~I_MS_BTk.n
               & (~w_full | w_pop);

`ifdef ARB_FIXED_PRIO_EN
  assign w_gnt_id = ~w_pend0;
`else
  logic r_rr_ptr;

  assign w_gnt_id = (w_pend0 & w_pend1) ? r_rr_ptr : w_pend1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt) begin
      r_rr_ptr <= ~w_gnt_id;
    end
  end
`endif

  assign w_count_nxt = r_count + (c_PW+1)'(w_gnt) - (c_PW+1)'(w_pop);

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (I_Active) w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (!I_Active) w_state_nxt = (w_count_nxt == '0) ? c_IDLE : c_DRAIN;
      end
      c_DRAIN: begin
        if (I_Active)                w_state_nxt = c_RUN;
        else if (w_count_nxt == '0)  w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_run   = (r_state == c_RUN);
    O_State = r_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_gnt) begin
        r_tag[r_wptr] <= w_gnt_id;
        r_wptr        <= r_wptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ms_en <= 1'b0;
      r_ms_op <= '0;
      r_ms_a  <= '0;
      r_ms_b  <= '0;
    end else if (w_gnt) begin
      r_ms_en <= 1'b1;
      r_ms_op <= w_gnt_id ? I_Opcode1 : I_Opcode0;
      r_ms_a  <= w_gnt_id ? I_FTkA1   : I_FTkA0;
      r_ms_b  <= w_gnt_id ? I_FTkB1   : I_FTkB0;
    end else begin
      r_ms_en <= 1'b0;
      r_ms_op <= '0;
      r_ms_a  <= '0;
      r_ms_b  <= '0;
    end
  end

  // A stalled destination keeps its registered result; everything else is a one-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_res0 <= '0;
      r_res1 <= '0;
      r_err  <= 1'b0;
    end else begin
      if (!(w_stall && !w_head)) begin
        r_res0 <= ((w_pop | w_rel) && !w_head) ? I_MS_Result : '0;
      end
      if (!(w_stall && w_head)) begin
        r_res1 <= ((w_pop | w_rel) && w_head) ? I_MS_Result : '0;
      end
      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_nack0 = reset & w_pend0 & ~(w_gnt & ~w_gnt_id);
  assign w_nack1 = reset & w_pend1 & ~(w_gnt &  w_gnt_id);

  assign O_BTk0        = BTk_t'({w_nack0, 3'b000});
  assign O_BTk1        = BTk_t'({w_nack1, 3'b000});
  assign O_MS_BTk      = BTk_t'({reset & w_stall, 3'b000});
  assign O_MS_EnSrc    = r_ms_en;
  assign O_MS_Opcode   = r_ms_op;
  assign O_MS_OperandA = r_ms_a;
  assign O_MS_OperandB = r_ms_b;
  assign O_Result0     = r_res0;
  assign O_Result1     = r_res1;
  assign O_Err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ms_arbiter.sv
// tb_ms_arbiter: directed scoreboard bench for ms_arbiter (DEPTH_TAG=4).
`default_nettype none

module tb_ms_arbiter;
  import ms_arbiter_pkg::*;

  localparam int c_NONE = 0;
  localparam int c_POP  = 1;
  localparam int c_HOLD = 2;
  localparam int c_REL  = 3;

  logic       clk;
  logic       rst_n;
  logic       active;
  opcode_ms_t op0, op1;
  FTk_t       a0, b0, a1, b1, ms_res;
  BTk_t       btk0_in, btk1_in, ms_btk_in;

  BTk_t       o_btk0, o_btk1, o_ms_btk;
  FTk_t       o_res0, o_res1, o_ms_a, o_ms_b;
  opcode_ms_t o_ms_op;
  logic       o_ms_en, o_err;
  logic [1:0] o_state;

  int n_vec = 0;
  int n_mis = 0;

  logic [40:0] q_ms[$];
  FTk_t        q_r0[$];
  FTk_t        q_r1[$];
  int          q_tag[$];
  FTk_t        last0, last1;

  ms_arbiter #(.DEPTH_TAG(4)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .I_Active     (active),
    .I_Opcode0    (op0),
    .I_Opcode1    (op1),
    .I_FTkA0      (a0),
    .I_FTkB0      (b0),
    .I_FTkA1      (a1),
    .I_FTkB1      (b1),
    .O_BTk0       (o_btk0),
    .O_BTk1       (o_btk1),
    .O_Result0    (o_res0),
    .O_Result1    (o_res1),
    .I_BTk0       (btk0_in),
    .I_BTk1       (btk1_in),
    .O_MS_Opcode  (o_ms_op),
    .O_MS_OperandA(o_ms_a),
    .O_MS_OperandB(o_ms_b),
    .O_MS_EnSrc   (o_ms_en),
    .I_MS_BTk     (ms_btk_in),
    .I_MS_Result  (ms_res),
    .O_MS_BTk     (o_ms_btk),
    .O_State      (o_state),
    .O_Err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit p0, input bit p1);
    op0 = 4'($urandom);
    op1 = 4'($urandom);
    a0  = '{v: p0, r: 1'b0, d: 16'($urandom)};
    b0  = '{v: p0, r: 1'b0, d: 16'($urandom)};
    a1  = '{v: p1, r: 1'b0, d: 16'($urandom)};
    b1  = '{v: p1, r: 1'b0, d: 16'($urandom)};
  endtask

  function automatic FTk_t mk_res(input bit v, input bit r);
    FTk_t t;
    t = '{v: v, r: r, d: 16'($urandom)};
    return t;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 64'(o_state), 64'd0);
    chk({tag, "_err"},   64'(o_err),   64'd0);
    chk({tag, "_ms"},    64'({o_ms_en, o_ms_op, o_ms_a, o_ms_b}), 64'd0);
    chk({tag, "_res"},   64'({o_res0, o_res1}), 64'd0);
    chk({tag, "_btk"},   64'({o_btk0, o_btk1, o_ms_btk}), 64'd0);
  endtask

  // Inputs already driven; g = expected grantee (-1 none), rmode = expected result routing.
  task automatic cycle(input int g, input int rmode);
    logic [40:0] w;
    logic [40:0] got_ms;
    FTk_t e0, e1, x0, x1;
    bit   p0, p1, stall;
    int   k;
    p0 = a0.v & b0.v;
    p1 = a1.v & b1.v;
    stall = (q_tag.size() > 0) && ((q_tag[0] == 0) ? btk0_in.n : btk1_in.n);
    #1;
    chk("btk0", 64'(o_btk0), 64'({p0 && (g != 0), 3'b000}));
    chk("btk1", 64'(o_btk1), 64'({p1 && (g != 1), 3'b000}));
    chk("ms_btk", 64'(o_ms_btk), 64'({stall, 3'b000}));
    if (g == 0)      w = {1'b1, op0, a0, b0};
    else if (g == 1) w = {1'b1, op1, a1, b1};
    else             w = '0;
    q_ms.push_back(w);
    e0 = '0;
    e1 = '0;
    case (rmode)
      c_POP: begin
        k = q_tag.pop_front();
        if (k == 0) e0 = ms_res; else e1 = ms_res;
      end
      c_HOLD: begin
        k = q_tag[0];
        if (k == 0) e0 = last0; else e1 = last1;
      end
      c_REL: begin
        k = q_tag[0];
        if (k == 0) e0 = ms_res; else e1 = ms_res;
      end
      default: ;
    endcase
    q_r0.push_back(e0);
    q_r1.push_back(e1);
    if (g >= 0) q_tag.push_back(g);
    @(posedge clk);
    #1;
    got_ms = {o_ms_en, o_ms_op, o_ms_a, o_ms_b};
    w  = q_ms.pop_front();
    x0 = q_r0.pop_front();
    x1 = q_r1.pop_front();
    chk("ms_out", 64'(got_ms), 64'(w));
    chk("res0", 64'(o_res0), 64'(x0));
    chk("res1", 64'(o_res1), 64'(x1));
    last0 = x0;
    last1 = x1;
  endtask

  function automatic int exp_both(input int rr);
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return rr;
`endif
  endfunction

  initial begin
    rst_n     = 1'b1;
    active    = 1'b0;
    set_req(0, 0);
    ms_res    = '0;
    btk0_in   = '0;
    btk1_in   = '0;
    ms_btk_in = '0;
    last0     = '0;
    last1     = '0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle", 64'(o_state), 64'd0);

    active = 1'b1;
    cycle(-1, c_NONE);
    chk("run", 64'(o_state), 64'd1);

    // Both pending: alternate 0,1,0,1 and fill the tag FIFO.
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1);
      cycle(exp_both(i % 2), c_NONE);
    end
    set_req(1, 1);
    cycle(-1, c_NONE);
    set_req(1, 1);
    ms_res = mk_res(1, 0);
    cycle(0, c_POP);
    ms_res = '0;
    set_req(1, 1);
    cycle(-1, c_NONE);

    set_req(0, 0);
    for (int i = 0; i < 4; i++) begin
      ms_res = mk_res(1, 0);
      cycle(-1, c_POP);
    end
    ms_res = '0;

    // Consumer 0 back-pressure on the head result.
    set_req(1, 0);
    cycle(0, c_NONE);
    set_req(0, 1);
    cycle(1, c_NONE);
    set_req(0, 0);
    ms_res    = mk_res(1, 0);
    btk0_in.n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(-1, c_HOLD);
    btk0_in.n = 1'b0;
    cycle(-1, c_POP);
    ms_res = mk_res(1, 0);
    cycle(-1, c_POP);
    ms_res = '0;
    cycle(-1, c_NONE);

    // Release token goes to the head destination without popping.
    set_req(0, 1);
    cycle(1, c_NONE);
    set_req(0, 0);
    ms_res = mk_res(0, 1);
    cycle(-1, c_REL);
    ms_res = mk_res(1, 0);
    cycle(-1, c_POP);
    ms_res = '0;

    // Drain with two outstanding.
    set_req(1, 1);
    cycle(exp_both(0), c_NONE);
    set_req(1, 1);
    cycle(exp_both(1), c_NONE);
    set_req(0, 0);
    active = 1'b0;
    cycle(-1, c_NONE);
    chk("drain", 64'(o_state), 64'd2);
    set_req(1, 1);
    cycle(-1, c_NONE);
    chk("drain_nogrant", 64'(o_state), 64'd2);
    set_req(0, 0);
    ms_res = mk_res(1, 0);
    cycle(-1, c_POP);
    chk("drain_one_left", 64'(o_state), 64'd2);
    ms_res = mk_res(1, 0);
    cycle(-1, c_POP);
    chk("drain_done", 64'(o_state), 64'd0);

    // Orphan result with an empty FIFO.
    chk("err_clear", 64'(o_err), 64'd0);
    ms_res = mk_res(1, 0);
    cycle(-1, c_NONE);
    chk("err_set", 64'(o_err), 64'd1);
    ms_res = '0;
    cycle(-1, c_NONE);
    cycle(-1, c_NONE);
    chk("err_sticky", 64'(o_err), 64'd1);

    // Reset with three outstanding.
    active = 1'b1;
    cycle(-1, c_NONE);
    set_req(1, 0);
    cycle(0, c_NONE);
    set_req(0, 1);
    cycle(1, c_NONE);
    set_req(1, 0);
    cycle(0, c_NONE);
    set_req(1, 1);
    rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    q_tag.delete();
    last0  = '0;
    last1  = '0;
    active = 1'b0;
    set_req(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ms_res = mk_res(1, 0);
    cycle(-1, c_NONE);
    chk("err_after_rst", 64'(o_err), 64'd1);
    ms_res = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
